// File: rtl/mem_arbiter_if.sv
// Bundle of IF/MEM request ports and the shared memory port around mem_arbiter.
// The arbiter uses the slave modport. The pipeline and memory side uses the master modport.
interface mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between IF fetches and MEM loads/stores.
// Define MEM_ARB_STARVE_GUARD_EN to let IF through after STARVE_MAX consecutive data grants.
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state;
    state_t            state_next;
    logic              gnt_dm;
    logic              grant;
    logic              grant_dm;
    logic              capture;
    logic              starve_hit;
    logic              mem_en_c;
    logic              if_ack_c;
    logic              dm_ack_c;
    logic              busy_c;
    logic [2:0]        lat_cnt;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;

    assign starve_hit = (starve_cnt == SW'(STARVE_MAX));

    // Only data grants that overtake a waiting fetch count toward starvation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (grant_dm && bus.if_req) starve_cnt <= starve_cnt + SW'(1);
            else                        starve_cnt <= '0;
        end
    end
`else
    // STARVE_MAX is always positive, so this is a constant 0 and the data side always wins.
    assign starve_hit = (STARVE_MAX < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_dm   = 1'b0;
        capture    = 1'b0;
        mem_en_c   = 1'b0;
        if_ack_c   = 1'b0;
        dm_ack_c   = 1'b0;
        busy_c     = (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.dm_req || bus.if_req) begin
                    grant      = 1'b1;
                    grant_dm   = bus.dm_req && !(bus.if_req && starve_hit);
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en_c   = 1'b1;
                state_next = mem_we_q ? ACK : WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd1) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if_ack_c   = !gnt_dm;
                dm_ack_c   = gnt_dm;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command registers drive the memory port directly, so they load only at grant time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_dm      <= 1'b0;
            lat_cnt     <= 3'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (grant) begin
                gnt_dm     <= grant_dm;
                mem_we_q   <= grant_dm && bus.dm_we;
                mem_addr_q <= grant_dm ? bus.dm_addr : bus.if_addr;
                if (grant_dm) mem_wdata_q <= bus.dm_wdata;
            end
            if (state == ISSUE)     lat_cnt <= 3'(MEM_LAT);
            else if (state == WAIT) lat_cnt <= lat_cnt - 3'd1;
            if (capture) begin
                if (gnt_dm) dm_rdata_q <= bus.mem_rdata;
                else        if_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_c;
    assign bus.dm_ack    = dm_ack_c;
    assign busy          = busy_c;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3, each on a behavioural memory.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic busy1;
    logic busy3;

    mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b1 ();
    mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b3 ();

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (b1),
        .busy(busy1)
    );

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
        .clk (clk),
        .rst (rst),
        .bus (b3),
        .busy(busy3)
    );

    always #5 clk = ~clk;

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] rd1 = '0;
    logic [31:0] pipe3 [0:2];
    logic        pre_en = 1'b0;
    logic        pre_sel = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    // Behavioural single-port memories; the MEM_LAT=3 one delays read data through a 3-stage pipe.
    always @(posedge clk) begin
        if (pre_en && !pre_sel) mem1[pre_addr] <= pre_data;
        if (pre_en && pre_sel)  mem3[pre_addr] <= pre_data;
        if (b1.mem_en) begin
            if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
            rd1 <= mem1[b1.mem_addr];
        end
        if (b3.mem_en) begin
            if (b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
            pipe3[0] <= mem3[b3.mem_addr];
        end else begin
            pipe3[0] <= '0;
        end
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign b1.mem_rdata = rd1;
    assign b3.mem_rdata = pipe3[2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel3, input logic ifr, input logic [9:0] ia,
                                 input logic dr, input logic dwe, input logic [9:0] da,
                                 input logic [31:0] dd);
        if (sel3) begin
            b3.if_req = ifr; b3.if_addr = ia;
            b3.dm_req = dr;  b3.dm_we = dwe; b3.dm_addr = da; b3.dm_wdata = dd;
        end else begin
            b1.if_req = ifr; b1.if_addr = ia;
            b1.dm_req = dr;  b1.dm_we = dwe; b1.dm_addr = da; b1.dm_wdata = dd;
        end
    endtask

    task automatic preload(input bit sel3, input logic [9:0] addr, input logic [31:0] data);
        pre_sel  = sel3;
        pre_addr = addr;
        pre_data = data;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_en;
        int n_ack;
        int n_starve;
        int exp_if_pos;
        int ack_k;
        logic [31:0] got_data;
        logic [31:0] acks [0:7];

        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        checkOutput("reset_busy3", busy3, 0);
        checkOutput("reset_mem_en3", b3.mem_en, 0);
        checkOutput("reset_mem_we3", b3.mem_we, 0);
        checkOutput("reset_if_ack1", b1.if_ack, 0);
        checkOutput("reset_dm_ack3", b3.dm_ack, 0);
        checkOutput("reset_mem_addr1", b1.mem_addr, 0);
        checkOutput("reset_dm_rdata3", b3.dm_rdata, 0);
        rst = 1'b0;

        preload(1'b0, 10'h005, 32'h8C010004);
        preload(1'b0, 10'h001, 32'h11111111);
        preload(1'b0, 10'h020, 32'h22222222);
        preload(1'b1, 10'h007, 32'hCAFEF00D);

        // Single IF read with MEM_LAT=1
        applyStimulus(1'b0, 1'b1, 10'h005, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("if_rd_mem_en", b1.mem_en, 1);
        checkOutput("if_rd_mem_addr", b1.mem_addr, 32'h005);
        checkOutput("if_rd_mem_we", b1.mem_we, 0);
        @(negedge clk);
        checkOutput("if_rd_early_ack", b1.if_ack, 0);
        @(negedge clk);
        checkOutput("if_rd_ack", b1.if_ack, 1);
        checkOutput("if_rd_data", b1.if_rdata, 32'h8C010004);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("if_rd_busy_after", busy1, 0);

        // Store then load with MEM_LAT=3
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 10'h010, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("st_mem_en", b3.mem_en, 1);
        checkOutput("st_mem_we", b3.mem_we, 1);
        checkOutput("st_mem_wdata", b3.mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("st_ack", b3.dm_ack, 1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h010, '0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("ld_ack_c%0d", k), b3.dm_ack, (k == 5));
        end
        checkOutput("ld_data", b3.dm_rdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Simultaneous IF and DM requests: DM first, IF after the separating IDLE
        applyStimulus(1'b0, 1'b1, 10'h001, 1'b1, 1'b0, 10'h020, '0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput($sformatf("sim_dm_ack_c%0d", k), b1.dm_ack, (k == 3));
            checkOutput($sformatf("sim_if_ack_c%0d", k), b1.if_ack, (k == 7));
            if (k == 3) begin
                checkOutput("sim_dm_data", b1.dm_rdata, 32'h22222222);
                applyStimulus(1'b0, 1'b1, 10'h001, 1'b0, 1'b0, '0, '0);
            end
            if (k >= 5) checkOutput($sformatf("sim_if_we_c%0d", k), b1.mem_we, 0);
            if (k == 5) begin
                checkOutput("sim_if_mem_en", b1.mem_en, 1);
                checkOutput("sim_if_mem_addr", b1.mem_addr, 32'h001);
            end
        end
        checkOutput("sim_if_data", b1.if_rdata, 32'h11111111);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Ack hold-off: dm_req held through ACK, dropped in the following IDLE cycle
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 10'h020, '0);
        n_en  = 0;
        n_ack = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_en  += int'(b1.mem_en);
            n_ack += int'(b1.dm_ack);
            if (k == 4) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        end
        checkOutput("hold_dm_ack_count", n_ack, 1);
        checkOutput("hold_mem_en_count", n_en, 1);

        // Starvation: both requests held; record the order of acks on the MEM_LAT=3 instance
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_if_pos = 4;
`else
        exp_if_pos = -1;
`endif
        for (int i = 0; i < 8; i++) acks[i] = 32'hFF;
        n_starve = 0;
        applyStimulus(1'b1, 1'b1, 10'h007, 1'b1, 1'b0, 10'h010, '0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (b3.dm_ack || b3.if_ack) begin
                if (n_starve < 8) acks[n_starve] = {31'd0, b3.if_ack};
                n_starve++;
            end
        end
        checkOutput("starve_ack_count", n_starve, 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("starve_grant_%0d_is_if", i), acks[i], (i == exp_if_pos));
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (8) @(negedge clk);

        // Reset asserted in the second WAIT cycle of an IF read
        applyStimulus(1'b1, 1'b1, 10'h007, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy3, 0);
        checkOutput("midrst_mem_en", b3.mem_en, 0);
        checkOutput("midrst_if_ack", b3.if_ack, 0);
        checkOutput("midrst_if_rdata", b3.if_rdata, 0);
        checkOutput("midrst_dm_rdata", b3.dm_rdata, 0);
        checkOutput("midrst_mem_addr", b3.mem_addr, 0);
        n_ack = 0;
        repeat (3) begin
            @(negedge clk);
            n_ack += int'(b3.if_ack);
        end
        checkOutput("midrst_no_ack_in_reset", n_ack, 0);
        rst = 1'b0;
        ack_k    = 0;
        got_data = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (b3.if_ack) begin
                n_ack++;
                ack_k    = k;
                got_data = b3.if_rdata;
                applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
            end
        end
        checkOutput("midrst_recover_ack_count", n_ack, 1);
        checkOutput("midrst_recover_latency", ack_k, 5);
        checkOutput("midrst_recover_data", got_data, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single-port synchronous memory between the IF-stage instruction fetch and the MEM-stage load/store, so the pipeline can run from one unified memory instead of separate instruction and data memories. It accepts one outstanding request per requester and arbitrates with data-over-instruction priority. A multi-state FSM sequences each access and returns a one-cycle acknowledge. Pipeline control treats `req & ~ack` on either side as a stall for that stage.

## Interface

Parameters:
- `ADDR_W`, 10: word-address width; byte address bits [11:2].
- `DATA_W`, 32: data width.
- `MEM_LAT`, 1: read latency of the memory in cycles, legal range 1..7.
- `STARVE_MAX`, 4: number of consecutive data grants allowed while IF waits. Used only with the guard macro.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `if_req`, in, 1: instruction fetch request. Held until `if_ack`.
- `if_addr`, in, ADDR_W: fetch word address. Stable while `if_req` is high.
- `if_rdata`, out, DATA_W: fetched instruction. Valid when `if_ack` is high.
- `if_ack`, out, 1: one-cycle completion pulse for IF.
- `dm_req`, in, 1: data request. Held until `dm_ack`.
- `dm_we`, in, 1: 1 = store, 0 = load.
- `dm_addr`, in, ADDR_W: data word address.
- `dm_wdata`, in, DATA_W: store data.
- `dm_rdata`, out, DATA_W: load data. Valid when `dm_ack` is high.
- `dm_ack`, out, 1: one-cycle completion pulse for MEM.
- `mem_en`, out, 1: memory access strobe.
- `mem_we`, out, 1: memory write enable. Only meaningful with `mem_en`.
- `mem_addr`, out, ADDR_W: memory address.
- `mem_wdata`, out, DATA_W: memory write data.
- `mem_rdata`, in, DATA_W: memory read data. Valid MEM_LAT cycles after the `mem_en` cycle.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation

- FSM states are IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - Otherwise grant one requester and register its command (`gnt_dm`, we, addr, wdata) into the `mem_*` output registers, then go to ISSUE.
  - Priority: `dm_req` wins over `if_req`. The MEM-stage instruction is older.
- **ISSUE**
  - `mem_en` = 1 for exactly one cycle.
  - A write goes to ACK. A read goes to WAIT and loads the latency counter with MEM_LAT.
- **WAIT**
  - The 3-bit counter decrements each cycle.
  - When the counter reaches 1, capture `mem_rdata` into the granted side's rdata register, then go to ACK.
- **ACK**
  - Pulse `if_ack` or `dm_ack` for the granted side; a store also acks with `dm_ack`.
  - Next state is always IDLE.
  - Requests are not sampled in ACK, so a requester still holding req during ACK is never granted twice.
- `if_rdata` and `dm_rdata` are registered and hold their last captured value until the next read for that side.
- `mem_en` is low in every state except ISSUE. `mem_we` is forced to 0 for IF grants.
- Reset mid-operation:
  - All state is cleared immediately and the in-flight access is discarded; no ack is produced.
  - A write already strobed into memory stands.

## Timing

- Reset values: state IDLE; `if_ack`, `dm_ack`, `mem_en`, `mem_we`, `busy` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0; starvation counter = 0.
- Take cycle T as the IDLE cycle in which the request is sampled.
  - ISSUE occurs at T+1.
  - Write ack at T+2.
  - Read data is sampled from `mem_rdata` at the end of cycle T+1+MEM_LAT; read ack at T+2+MEM_LAT.
  - With MEM_LAT=1: read ack at T+3.
- Throughput: one access per 3 cycles for writes and per MEM_LAT+3 cycles for reads. IDLE always separates two accesses.
- Simultaneous `if_req` and `dm_req` in IDLE: the data access is granted first. IF is granted at the next IDLE, provided `dm_req` has dropped or the starvation guard fires.
- Request inputs are ignored outside IDLE. Changing addr or data while req is held is a protocol violation, and the behaviour is undefined.

## Configuration

- Macro `MEM_ARB_STARVE_GUARD_EN`.
- **Defined:** a counter counts consecutive data grants made while `if_req` is high.
  - When the counter equals STARVE_MAX and both requests are high in IDLE, IF is granted and the counter clears.
  - The counter also clears on any IF grant, and on any data grant made while `if_req` is low.
- **Undefined:** strict data priority, and no counter logic is generated.

## Test plan

- **Single IF read, MEM_LAT=1.** Preload word 0x005 with 0x8C010004; `if_req` with addr 0x005 at T.
  - `mem_en` at T+1 with `mem_addr`=0x005.
  - `if_ack`=1 and `if_rdata`=0x8C010004 at T+3; `busy` low at T+4.
- **Store then load, MEM_LAT=3.** Store 0xDEADBEEF to 0x010; ack at T+2. Then load 0x010.
  - `dm_ack` with `dm_rdata`=0xDEADBEEF exactly 5 cycles after the load's IDLE sample.
- **Simultaneous requests** (IF addr 0x001, DM load addr 0x020).
  - DM is served first; `if_ack` arrives only after `dm_ack` plus the IDLE and full IF access.
  - `mem_we` is never 1 during the IF access.
- **Starvation, macro defined, STARVE_MAX=4.** `dm_req` and `if_req` held high continuously.
  - Grant order DM, DM, DM, DM, IF, DM…
  - With the macro undefined, IF is never acked.
- **Reset mid-read, MEM_LAT=3.** Assert `rst` in the second WAIT cycle.
  - Outputs return to reset values asynchronously, and no ack ever pulses for that request.
  - After release, a re-held `if_req` completes normally.
- **Ack hold-off.** The requester keeps `dm_req` high through the ACK cycle and drops it the cycle after.
  - Exactly one `dm_ack` pulse and exactly one `mem_en` pulse occur.
